// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle of the PC redirect unit: stall/redirect requests in,
// fetch address and flush/status pulses out.
interface pc_redirect_unit_if;
  logic        stall;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        exc_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_ifid;
  logic        redirect_pending;
  logic        misalign_err;

  modport master (
    output stall, jump_valid, jump_target, branch_valid, branch_target, exc_valid,
    input  pc, pc_plus4, flush_ifid, redirect_pending, misalign_err
  );

  modport slave (
    input  stall, jump_valid, jump_target, branch_valid, branch_target, exc_valid,
    output pc, pc_plus4, flush_ifid, redirect_pending, misalign_err
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with exception/branch/jump redirect; redirects that arrive
// while fetch is stalled are parked in pend_target until the stall clears.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic                clk,
  input  logic                reset,
  pc_redirect_unit_if.slave   bus
);

  typedef enum logic {RUN, PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        req_valid;
  logic [31:0] req_target;

  // Branch outranks jump; a misaligned winner becomes an exception redirect
  // at once, so only word-aligned addresses are ever parked.
  always_comb begin
    req_valid     = bus.branch_valid | bus.jump_valid;
    req_target    = bus.branch_valid ? bus.branch_target : bus.jump_target;
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;

    if (bus.exc_valid) begin
      pc_d          = EXC_VECTOR;
      pend_target_d = 32'h0000_0000;
      flush_d       = 1'b1;
      state_d       = RUN;
    end else if (state_q == PEND) begin
      if (!bus.stall) begin
        pc_d    = pend_target_q;
        flush_d = 1'b1;
        state_d = RUN;
      end
    end else if (req_valid) begin
      if (req_target[1:0] != 2'b00) begin
        pc_d       = EXC_VECTOR;
        flush_d    = 1'b1;
        misalign_d = 1'b1;
      end else if (bus.stall) begin
        pend_target_d = req_target;
        state_d       = PEND;
      end else begin
        pc_d    = req_target;
        flush_d = 1'b1;
      end
    end else if (!bus.stall) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0000_0000;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus4         = pc_q + 32'd4;
  assign bus.flush_ifid       = flush_q;
  assign bus.redirect_pending = (state_q == PEND);
  assign bus.misalign_err     = misalign_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: two instances (default reset PC and a
// wrap-around reset PC) share one stimulus stream and are tracked by a model.
module tb_pc_redirect_unit;

  localparam logic [31:0] EXC_VEC  = 32'h8000_0180;
  localparam logic [31:0] ALT_RST  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  pc_redirect_unit_if if0 ();
  pc_redirect_unit_if if1 ();

  pc_redirect_unit dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  pc_redirect_unit #(.RESET_PC(ALT_RST)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  assign if1.stall         = if0.stall;
  assign if1.jump_valid    = if0.jump_valid;
  assign if1.jump_target   = if0.jump_target;
  assign if1.branch_valid  = if0.branch_valid;
  assign if1.branch_target = if0.branch_target;
  assign if1.exc_valid     = if0.exc_valid;

  always #5 clk = ~clk;

  // Model: the fetch address plus an optional parked redirect per instance.
  logic [31:0] m_pc [2];
  logic [31:0] m_pend [2];
  bit          m_has_pend [2];
  bit          m_flush [2];
  bit          m_mis [2];
  bit          m_valid = 1'b0;
  logic [31:0] m_rst_pc [2];

  initial begin
    m_rst_pc[0] = 32'h0000_0000;
    m_rst_pc[1] = ALT_RST;
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [31:0] tgt;
      if (reset) begin
        m_pc[m]       = m_rst_pc[m];
        m_has_pend[m] = 1'b0;
        m_pend[m]     = 32'h0;
        m_flush[m]    = 1'b0;
        m_mis[m]      = 1'b0;
      end else begin
        m_flush[m] = 1'b0;
        m_mis[m]   = 1'b0;
        if (if0.exc_valid) begin
          m_pc[m]       = EXC_VEC;
          m_flush[m]    = 1'b1;
          m_has_pend[m] = 1'b0;
        end else if (m_has_pend[m]) begin
          if (!if0.stall) begin
            m_pc[m]       = m_pend[m];
            m_flush[m]    = 1'b1;
            m_has_pend[m] = 1'b0;
          end
        end else if (if0.branch_valid || if0.jump_valid) begin
          tgt = if0.branch_valid ? if0.branch_target : if0.jump_target;
          if ((tgt % 4) != 0) begin
            m_pc[m]    = EXC_VEC;
            m_flush[m] = 1'b1;
            m_mis[m]   = 1'b1;
          end else if (if0.stall) begin
            m_has_pend[m] = 1'b1;
            m_pend[m]     = tgt;
          end else begin
            m_pc[m]    = tgt;
            m_flush[m] = 1'b1;
          end
        end else if (!if0.stall) begin
          m_pc[m] = m_pc[m] + 32'd4;
        end
      end
    end
    if (reset) m_valid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic compare_dut(input int m, input logic [31:0] pc, input logic [31:0] pc4,
                             input logic flush, input logic pend, input logic mis);
    checkOutput($sformatf("dut%0d.pc", m), pc, m_pc[m]);
    checkOutput($sformatf("dut%0d.pc_plus4", m), pc4, m_pc[m] + 32'd4);
    checkOutput($sformatf("dut%0d.flush_ifid", m), {31'b0, flush}, {31'b0, m_flush[m]});
    checkOutput($sformatf("dut%0d.redirect_pending", m), {31'b0, pend}, {31'b0, m_has_pend[m]});
    checkOutput($sformatf("dut%0d.misalign_err", m), {31'b0, mis}, {31'b0, m_mis[m]});
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      compare_dut(0, if0.pc, if0.pc_plus4, if0.flush_ifid, if0.redirect_pending, if0.misalign_err);
      compare_dut(1, if1.pc, if1.pc_plus4, if1.flush_ifid, if1.redirect_pending, if1.misalign_err);
    end
  end

  task automatic applyStimulus(input logic rst, input logic stall,
                               input logic jv, input logic [31:0] jt,
                               input logic bv, input logic [31:0] bt,
                               input logic ev);
    reset             = rst;
    if0.stall         = stall;
    if0.jump_valid    = jv;
    if0.jump_target   = jt;
    if0.branch_valid  = bv;
    if0.branch_target = bt;
    if0.exc_valid     = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic stall);
    applyStimulus(1'b0, stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset pc", if0.pc, 32'h0);
    checkOutput("reset alt pc", if1.pc, 32'hFFFF_FFF8);
    checkOutput("reset flush", {31'b0, if0.flush_ifid}, 32'h0);

    idle(1'b0);
    checkOutput("run pc 4", if0.pc, 32'h4);
    idle(1'b0);
    checkOutput("alt pc wrap", if1.pc, 32'h0);
    idle(1'b0);
    checkOutput("run pc C", if0.pc, 32'hC);
    idle(1'b0);
    checkOutput("run pc 10", if0.pc, 32'h10);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
    checkOutput("jump pc", if0.pc, 32'h0040_0100);
    checkOutput("jump flush", {31'b0, if0.flush_ifid}, 32'h1);
    idle(1'b0);
    checkOutput("jump pc+4", if0.pc, 32'h0040_0104);
    checkOutput("jump flush drop", {31'b0, if0.flush_ifid}, 32'h0);

    idle(1'b1);
    checkOutput("stall hold", if0.pc, 32'h0040_0104);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b0);
    checkOutput("pc at 20", if0.pc, 32'h20);

    // Branch beats jump; both arrive while stalled.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
    checkOutput("pend hold pc", if0.pc, 32'h20);
    checkOutput("pend flag", {31'b0, if0.redirect_pending}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    checkOutput("pend ignore jump", if0.pc, 32'h20);
    idle(1'b1);
    checkOutput("pend still", {31'b0, if0.redirect_pending}, 32'h1);
    idle(1'b0);
    checkOutput("pend release pc", if0.pc, 32'h100);
    checkOutput("pend release flush", {31'b0, if0.flush_ifid}, 32'h1);
    idle(1'b0);
    checkOutput("pend after pc", if0.pc, 32'h104);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("exc pc", if0.pc, 32'h8000_0180);
    checkOutput("exc flush", {31'b0, if0.flush_ifid}, 32'h1);
    checkOutput("exc drops pend", {31'b0, if0.redirect_pending}, 32'h0);
    idle(1'b0);
    checkOutput("exc then run", if0.pc, 32'h8000_0184);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b0);
    checkOutput("misalign pc", if0.pc, 32'h8000_0180);
    checkOutput("misalign err", {31'b0, if0.misalign_err}, 32'h1);
    checkOutput("misalign flush", {31'b0, if0.flush_ifid}, 32'h1);
    idle(1'b0);
    checkOutput("misalign pulse", {31'b0, if0.misalign_err}, 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
    checkOutput("stalled misalign pc", if0.pc, 32'h8000_0180);
    checkOutput("stalled misalign pend", {31'b0, if0.redirect_pending}, 32'h0);
    idle(1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h500, 1'b1);
    checkOutput("exc priority", if0.pc, 32'h8000_0180);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h500, 1'b0);
    checkOutput("branch priority", if0.pc, 32'h500);

    // Reset while a redirect is parked and an exception is asserted.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("reset mid-pend alt pc", if1.pc, 32'hFFFF_FFF8);
    checkOutput("reset mid-pend flag", {31'b0, if1.redirect_pending}, 32'h0);
    checkOutput("reset mid-pend flush", {31'b0, if1.flush_ifid}, 32'h0);
    idle(1'b0);
    checkOutput("alt run 1", if1.pc, 32'hFFFF_FFFC);
    idle(1'b0);
    checkOutput("alt run 2", if1.pc, 32'h0000_0000);
    checkOutput("alt pc_plus4", if1.pc_plus4, 32'h0000_0004);
    idle(1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180, exception and misalignment redirect target.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  fetch/IF-ID stall from hazard unit; PC holds while high.
REQ-006 jump_valid  input  1  ID-stage jump resolved this cycle.
REQ-007 jump_target  input  32  composed jump address {PC+4[31:28], index, 2'b00}.
REQ-008 branch_valid  input  1  EX-stage branch taken this cycle.
REQ-009 branch_target  input  32  branch destination address.
REQ-010 exc_valid  input  1  exception request; redirects to EXC_VECTOR.
REQ-011 pc  output  32  current fetch address, registered.
REQ-012 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-013 flush_ifid  output  1  one-cycle pulse: discard instruction in IF/ID.
REQ-014 redirect_pending  output  1  high while a captured redirect waits on stall.
REQ-015 misalign_err  output  1  one-cycle pulse: selected target had nonzero bits [1:0].

Function
REQ-016 The block SHALL implement two states: RUN and PEND, plus a 32-bit pend_target register.
REQ-017 Request priority SHALL be exc_valid > branch_valid > jump_valid; only the winner is considered each cycle.
REQ-018 RUN, no request, stall=0: pc SHALL advance to pc+4 next cycle; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 RUN, no request, stall=1: pc SHALL hold; no outputs pulse.
REQ-020 RUN, branch or jump winner, stall=0: pc SHALL equal the target one cycle later, with flush_ifid=1 in that same cycle (latency 1).
REQ-021 RUN, branch or jump winner, stall=1: target SHALL be captured in pend_target, pc held, state to PEND; redirect_pending=1 from the next cycle.
REQ-022 PEND, stall=1: pc and pend_target SHALL hold; branch_valid/jump_valid SHALL be ignored.
REQ-023 PEND, stall=0: pc SHALL load pend_target next cycle, flush_ifid=1 that cycle, state to RUN, redirect_pending=0.
REQ-024 exc_valid SHALL redirect to EXC_VECTOR next cycle regardless of stall or state, pulse flush_ifid, discard any pending target, and enter RUN.
REQ-025 If the selected branch/jump target has bits [1:0] != 0, the block SHALL redirect to EXC_VECTOR instead, pulsing misalign_err and flush_ifid together; under stall=1 this is handled as in REQ-024.
REQ-026 Misalignment SHALL be checked at capture time; pend_target is always word-aligned.
REQ-027 pc_plus4 SHALL be combinationally pc+4 at all times.
REQ-028 flush_ifid and misalign_err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-029 reset=1 SHALL, at the next edge, set pc=RESET_PC, state=RUN, pend_target=0, flush_ifid=0, redirect_pending=0, misalign_err=0.
REQ-030 reset SHALL override all other inputs, including a pending redirect and a concurrent exc_valid.
REQ-031 After reset deasserts with stall=0 and no requests, pc SHALL sequence RESET_PC, RESET_PC+4, RESET_PC+8.

Verification
REQ-032 Reset, run 3 cycles -> pc 0x0,0x4,0x8,0xC; flush_ifid stays 0.
REQ-033 At pc=0x10, jump_valid with target 0x0040_0100, stall=0 -> next cycle pc=0x0040_0100, flush_ifid=1 one cycle, then 0x0040_0104.
REQ-034 At pc=0x20, branch 0x100 and jump 0x200 same cycle with stall=1 for 3 cycles -> pc holds 0x20, redirect_pending=1, new jump at cycle 2 ignored; on stall drop pc=0x100, flush_ifid=1.
REQ-035 PEND with target 0x300, exc_valid under stall -> next cycle pc=0x8000_0180, flush_ifid=1, redirect_pending=0.
REQ-036 jump_target 0x0000_0102 -> pc=0x8000_0180, misalign_err=1 and flush_ifid=1 one cycle.
REQ-037 RESET_PC=0xFFFF_FFF8, reset mid-PEND, then run -> pending dropped, pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
